sc_io_ctrl: RTL

- Memory-mapped I/O controller on the data-memory side of the single-cycle CPU.
- Consumes the CPU's ALU address, store data and write enable.
- Drives registered out_port0/out_port1 and returns read data for loads from I/O space.
- Synchronizes and debounces the raw in_port0/in_port1 board inputs and flags changes to software through a status register.

---
 rtl/sc_io_pkg.sv | 16 +
 rtl/sc_io_ctrl_if.sv | 22 ++
 rtl/sc_io_debounce.sv | 87 ++++++++
 rtl/sc_io_ctrl.sv | 121 ++++++++++++
 4 files changed

// File: rtl/sc_io_pkg.sv
// Shared constants for the memory-mapped I/O controller: register offsets,
// STATUS bit positions and the debounce counter width.
package sc_io_pkg;

  localparam logic [7:0] OFS_OUT0   = 8'h80;
  localparam logic [7:0] OFS_OUT1   = 8'h84;
  localparam logic [7:0] OFS_IN0    = 8'hC0;
  localparam logic [7:0] OFS_IN1    = 8'hC4;
  localparam logic [7:0] OFS_STATUS = 8'hC8;

  localparam int unsigned STAT_IN0 = 0;
  localparam int unsigned STAT_IN1 = 1;

  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/sc_io_ctrl_if.sv
// CPU data-side bus into the I/O controller. The CPU (master) drives the
// address, store data and store enable; the controller (slave) returns the
// I/O select and combinational load data.
interface sc_io_ctrl_if;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        io_sel;
  logic [31:0] rdata;

  modport master (
    output addr, wdata, we,
    input  io_sel, rdata
  );

  modport slave (
    input  addr, wdata, we,
    output io_sel, rdata
  );

endinterface

// File: rtl/sc_io_debounce.sv
// Two-flop synchronizer followed by a debouncer for one input port.
// Build option SC_IO_DEBOUNCE_EN: when defined, a change must hold for
// DEBOUNCE_CYCLES synchronized cycles before it reaches dout; when undefined,
// dout simply follows the synchronizer one cycle later and no counter exists.
// chg is a combinational pulse that is high in the cycle whose rising edge
// loads a new value into dout, so the parent can set its flag on that edge.
module sc_io_debounce
  import sc_io_pkg::*;
#(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             chg
);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [WIDTH-1:0] deb_q;

  // Metastability guard for the raw asynchronous board inputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= din;
      sync_q2 <= sync_q1;
    end
  end

`ifdef SC_IO_DEBOUNCE_EN

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] cand_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable;

  assign stable = (sync_q2 == cand_q);
  assign chg    = stable && (cnt_q == CNT_LAST) && (cand_q != deb_q);

  // Any movement restarts the count; a settled candidate that differs from
  // the accepted value is taken once the count reaches its last value, and
  // the count then saturates there instead of wrapping.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cand_q <= '0;
      cnt_q  <= '0;
      deb_q  <= '0;
    end else begin
      if (!stable) begin
        cand_q <= sync_q2;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_LAST) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (chg) begin
        deb_q <= cand_q;
      end
    end
  end

`else

  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES == 0);

  assign chg = (sync_q2 != deb_q);

  // Without debouncing the accepted value tracks the synchronizer directly.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      deb_q <= '0;
    end else begin
      deb_q <= sync_q2;
    end
  end

`endif

  assign dout = deb_q;

endmodule

// File: rtl/sc_io_ctrl.sv
// Memory-mapped I/O controller on the data-memory side of the single-cycle
// CPU: two registered output ports, two synchronized/debounced input ports,
// a write-1-to-clear change STATUS register and a registered irq.
// Build option SC_IO_DEBOUNCE_EN enables the input debouncers (see
// sc_io_debounce); without it inputs are only synchronized.
module sc_io_ctrl
  import sc_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter logic [7:0]  IO_BASE         = 8'h80
) (
  input  logic         clock,
  input  logic         resetn,
  sc_io_ctrl_if.slave  bus,
  input  logic [31:0]  in_port0,
  input  logic [31:0]  in_port1,
  output logic [31:0]  out_port0,
  output logic [31:0]  out_port1,
  output logic         irq
);

  logic [7:0]  ofs;
  logic        io_sel;
  logic        wr_en;
  logic [31:0] rdata_c;
  logic [31:0] in0_deb;
  logic [31:0] in1_deb;
  logic        in0_chg;
  logic        in1_chg;
  logic [1:0]  status_q;
  logic [1:0]  status_set;
  logic [1:0]  status_clr;
  logic [31:0] out0_q;
  logic [31:0] out1_q;
  logic        irq_q;
  logic        unused_addr;

  // Word offset within I/O space; byte lanes are ignored and only addr[7]
  // distinguishes I/O from data memory.
  assign ofs         = {bus.addr[7:2], 2'b00};
  assign io_sel      = (bus.addr[7] == IO_BASE[7]);
  assign wr_en       = bus.we && io_sel;
  assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

  sc_io_debounce #(
    .WIDTH          (32),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_in0 (
    .clock (clock),
    .resetn(resetn),
    .din   (in_port0),
    .dout  (in0_deb),
    .chg   (in0_chg)
  );

  sc_io_debounce #(
    .WIDTH          (32),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_in1 (
    .clock (clock),
    .resetn(resetn),
    .din   (in_port1),
    .dout  (in1_deb),
    .chg   (in1_chg)
  );

  // Zero-latency load data so single-cycle loads see I/O values directly.
  always_comb begin
    rdata_c = '0;
    if (io_sel) begin
      case (ofs)
        OFS_OUT0:   rdata_c = out0_q;
        OFS_OUT1:   rdata_c = out1_q;
        OFS_IN0:    rdata_c = in0_deb;
        OFS_IN1:    rdata_c = in1_deb;
        OFS_STATUS: rdata_c = {30'd0, status_q};
        default:    rdata_c = '0;
      endcase
    end
  end

  // Output port registers, loaded by stores to their offsets.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out0_q <= '0;
      out1_q <= '0;
    end else if (wr_en) begin
      if (ofs == OFS_OUT0) out0_q <= bus.wdata;
      if (ofs == OFS_OUT1) out1_q <= bus.wdata;
    end
  end

  assign status_set[STAT_IN0] = in0_chg;
  assign status_set[STAT_IN1] = in1_chg;
  assign status_clr = (wr_en && (ofs == OFS_STATUS)) ? bus.wdata[1:0] : 2'b00;

  // Change flags: clear first, then OR in new events so a same-cycle set wins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~status_clr) | status_set;
    end
  end

  // irq follows the flags one cycle later.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |status_q;
    end
  end

  assign bus.io_sel = io_sel;
  assign bus.rdata  = rdata_c;
  assign out_port0  = out0_q;
  assign out_port1  = out1_q;
  assign irq        = irq_q;

endmodule
